uart_tx_cfg: RTL and testbench

Runtime-configurable UART transmitter with an input FIFO. It is the successor to the fixed 8N1 transmitter in the logic-analyser upload path. Frame format and baud divisor are set at runtime: 5–8 data bits, none/even/odd/mark/space parity, and 1 or 2 stop bits. The baud counter restarts at every frame start, so each bit is exactly one divisor period. Consecutive bytes are sent back-to-back with no idle gap.

---
 rtl/uart_tx_cfg.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (5-8 data bits, none/even/odd/mark/space parity,
// 1 or 2 stop bits) fed by a byte FIFO; queued bytes are sent back-to-back.
module uart_tx_cfg #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  input  logic [DIV_W-1:0]            cfg_baud_div,
  input  logic [1:0]                  cfg_data_bits,
  input  logic [2:0]                  cfg_parity,
  input  logic                        cfg_stop2,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        tx_busy,
  output logic                        uart_tx
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CLK_FREQ == 0) begin : g_bad_param
    $error("uart_tx_cfg: FIFO_DEPTH must be a power of two >= 2 and CLK_FREQ nonzero");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [7:0]       shreg;
  logic [2:0]       bit_idx;
  logic [2:0]       last_idx;
  logic             par_en;
  logic             par_bit;
  logic             stop2_q;
  logic             stop_second;

  logic             tick;
  logic             frame_end;
  logic [7:0]       head;
  logic [7:0]       head_masked;
  logic [DIV_W-1:0] div_c;
  logic             par_en_c;
  logic             par_bit_c;

  assign tx_ready = (fifo_level != LW'(FIFO_DEPTH));
  assign push     = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  end

  // Frame parameters as they will be latched at the pop edge
  assign head        = mem[rd_ptr];
  assign head_masked = head & (8'hFF >> (2'd3 - cfg_data_bits));
  assign div_c       = (cfg_baud_div < DIV_W'(2)) ? DIV_W'(2) : cfg_baud_div;

  always_comb begin
    par_en_c  = 1'b1;
    par_bit_c = 1'b0;
    case (cfg_parity)
      3'd1:    par_bit_c = ^head_masked;
      3'd2:    par_bit_c = ~^head_masked;
      3'd3:    par_bit_c = 1'b1;
      3'd4:    par_bit_c = 1'b0;
      default: par_en_c  = 1'b0;
    endcase
  end

  assign tick      = (cnt == div_q - DIV_W'(1));
  assign frame_end = (state == STOP) && tick && (!stop2_q || stop_second);
  assign pop       = (fifo_level != '0) && ((state == IDLE) || frame_end);

  // A pop always starts a new frame, either from IDLE or straight out of the last stop tick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      div_q       <= DIV_W'(2);
      shreg       <= '0;
      bit_idx     <= '0;
      last_idx    <= '0;
      par_en      <= 1'b0;
      par_bit     <= 1'b0;
      stop2_q     <= 1'b0;
      stop_second <= 1'b0;
      tx_busy     <= 1'b0;
      uart_tx     <= 1'b1;
    end else if (pop) begin
      state       <= START;
      cnt         <= '0;
      div_q       <= div_c;
      shreg       <= head_masked;
      bit_idx     <= '0;
      last_idx    <= 3'd4 + 3'(cfg_data_bits);
      par_en      <= par_en_c;
      par_bit     <= par_bit_c;
      stop2_q     <= cfg_stop2;
      stop_second <= 1'b0;
      tx_busy     <= 1'b1;
      uart_tx     <= 1'b0;
    end else if (state != IDLE) begin
      cnt <= tick ? '0 : cnt + DIV_W'(1);
      if (tick) begin
        case (state)
          START: begin
            state   <= DATA;
            uart_tx <= shreg[0];
            shreg   <= shreg >> 1;
          end
          DATA: begin
            if (bit_idx == last_idx) begin
              state   <= par_en ? PARITY : STOP;
              uart_tx <= par_en ? par_bit : 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
          PARITY: begin
            state   <= STOP;
            uart_tx <= 1'b1;
          end
          STOP: begin
            if (stop2_q && !stop_second) begin
              stop_second <= 1'b1;
            end else begin
              state   <= IDLE;
              tx_busy <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: stimulus queues expected line frames, a monitor
// decodes the serial line cycle by cycle and compares against them.
module tb_uart_tx_cfg;
  localparam int unsigned DIV_W = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [DIV_W-1:0] cfg_baud_div;
  logic [1:0]       cfg_data_bits;
  logic [2:0]       cfg_parity;
  logic             cfg_stop2;
  logic [LW-1:0]    fifo_level;
  logic             tx_busy;
  logic             uart_tx;

  uart_tx_cfg #(.CLK_FREQ(50_000_000), .DIV_W(DIV_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cfg_baud_div(cfg_baud_div), .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2), .fifo_level(fifo_level), .tx_busy(tx_busy), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  // Expected frame: bits[0] is the start bit, then data LSB first, parity, stop bits
  typedef struct {
    logic [11:0] bits;
    int          nb;
    int          div;
    bit          b2b;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input logic [11:0] bits, input int nb, input int div, input bit b2b);
    exp_t e;
    e.bits = bits;
    e.nb   = nb;
    e.div  = div;
    e.b2b  = b2b;
    exp_q.push_back(e);
  endtask

  // Leaves tx_valid high so consecutive calls push on consecutive edges
  task automatic push(input logic [7:0] d);
    bit acc;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      acc = tx_ready;
      step(1);
      if (acc) return;
    end
    fail("push_timeout");
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    for (int k = 0; k < 3000; k++) begin
      if (tx_busy) n++;
      else if (n > 0) return;
      step(1);
    end
    fail("busy_timeout");
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 5000; k++) begin
      if (exp_q.size() == 0 && !tx_busy) return;
      step(1);
    end
    fail("idle_timeout");
  endtask

  // Monitor: checks every cycle of each frame and the gap before back-to-back frames
  initial begin : monitor
    exp_t        e;
    int          gap;
    int          bad;
    bit          aborted;
    logic [11:0] got;
    gap = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        gap = 0;
      end else if (uart_tx === 1'b1) begin
        gap++;
      end else if (exp_q.size() == 0) begin
        check("unexpected_start", 32'(uart_tx), 32'd1);
        for (int k = 0; k < 64 && uart_tx !== 1'b1; k++) @(negedge clk);
      end else begin
        e = exp_q.pop_front();
        if (e.b2b) check("gap_cycles", 32'(gap), 32'd0);
        got     = '0;
        bad     = 0;
        aborted = 1'b0;
        for (int c = 0; c < e.nb * e.div; c++) begin
          if (c > 0) @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          if (c % e.div == 0) got[c / e.div] = uart_tx;
          if (uart_tx !== e.bits[c / e.div]) bad++;
        end
        if (!aborted) begin
          check("frame_bits", 32'(got), 32'(e.bits));
          check("frame_timing", 32'(bad), 32'd0);
        end
        gap = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  par;
    logic [7:0]  data;
    logic [11:0] bits;
  } par_vec_t;

  initial begin : stim
    int       n;
    int       cyc;
    int       bad;
    logic [7:0] t4_bytes [6];
    par_vec_t pv [6];

    tx_data = '0; tx_valid = 1'b0; rst_n = 1'b0;
    cfg_baud_div = DIV_W'(4); cfg_data_bits = 2'b11; cfg_parity = 3'd0; cfg_stop2 = 1'b0;
    step(3);
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd1);
    rst_n = 1'b1;
    step(1);

    // 1: divisor 4, 8N1, 0xA5
    expect_frame({1'b1, 8'hA5, 1'b0}, 10, 4, 1'b0);
    push(8'hA5);
    tx_valid = 1'b0;
    check("t1_tx_before", 32'(uart_tx), 32'd1);
    step(1);
    check("t1_tx_low_next_edge", 32'(uart_tx), 32'd0);
    check("t1_busy_rise", 32'(tx_busy), 32'd1);
    measure_busy(n);
    check("t1_busy_cycles", 32'(n), 32'd40);
    wait_idle();

    // 2: 7 data bits with each parity mode; bit 7 of the byte never appears
    cfg_data_bits = 2'b10;
    pv[0] = '{3'd1, 8'hFF, {1'b1, 1'b1, 7'h7F, 1'b0}};
    pv[1] = '{3'd2, 8'hFF, {1'b1, 1'b0, 7'h7F, 1'b0}};
    pv[2] = '{3'd3, 8'h80, {1'b1, 1'b1, 7'h00, 1'b0}};
    pv[3] = '{3'd4, 8'hFF, {1'b1, 1'b0, 7'h7F, 1'b0}};
    pv[4] = '{3'd1, 8'h80, {1'b1, 1'b0, 7'h00, 1'b0}};
    pv[5] = '{3'd2, 8'h81, {1'b1, 1'b0, 7'h01, 1'b0}};
    for (int i = 0; i < 6; i++) begin
      cfg_parity = pv[i].par;
      expect_frame(pv[i].bits, 10, 4, 1'b0);
      push(pv[i].data);
      tx_valid = 1'b0;
      measure_busy(n);
      check("t2_busy_cycles", 32'(n), 32'd40);
      wait_idle();
    end

    // 3: divisor 3, 5 data bits, two stop bits, back-to-back
    cfg_baud_div = DIV_W'(3); cfg_data_bits = 2'b00; cfg_parity = 3'd0; cfg_stop2 = 1'b1;
    expect_frame({2'b11, 5'h13, 1'b0}, 8, 3, 1'b0);
    expect_frame({2'b11, 5'h0C, 1'b0}, 8, 3, 1'b1);
    push(8'h13);
    push(8'h0C);
    tx_valid = 1'b0;
    measure_busy(n);
    check("t3_busy_cycles", 32'(n), 32'd48);
    wait_idle();

    // 4: divisor 10, valid held high for 6 bytes into a 4-deep FIFO
    cfg_baud_div = DIV_W'(10); cfg_data_bits = 2'b11; cfg_stop2 = 1'b0;
    t4_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int i = 0; i < 6; i++) begin
      expect_frame({1'b1, t4_bytes[i], 1'b0}, 10, 10, i > 0);
      push(t4_bytes[i]);
      if (i == 4) begin
        check("t4_level_full", 32'(fifo_level), 32'd4);
        check("t4_ready_low", 32'(tx_ready), 32'd0);
      end
    end
    tx_valid = 1'b0;
    for (int k = 0; k < 1000 && fifo_level != '0; k++) step(1);
    check("t4_level_empty", 32'(fifo_level), 32'd0);
    cyc = 0;
    bad = 0;
    for (int k = 0; k < 1000 && tx_busy; k++) begin
      cyc++;
      if (tx_ready !== 1'b1 || fifo_level !== '0) bad++;
      step(1);
    end
    check("t4_last_frame_ready", 32'(bad), 32'd0);
    check("t4_last_frame_len", 32'(cyc), 32'd100);
    wait_idle();

    // 5: config change mid-frame only affects the next frame
    cfg_baud_div = DIV_W'(4); cfg_data_bits = 2'b11;
    expect_frame({1'b1, 8'h3C, 1'b0}, 10, 4, 1'b0);
    expect_frame({1'b1, 5'h15, 1'b0}, 7, 8, 1'b1);
    push(8'h3C);
    push(8'h15);
    tx_valid = 1'b0;
    step(3);
    cfg_data_bits = 2'b00;
    cfg_baud_div  = DIV_W'(8);
    wait_idle();

    // 6: reset during DATA with 3 bytes queued
    cfg_baud_div = DIV_W'(4); cfg_data_bits = 2'b11;
    expect_frame({1'b1, 8'hF0, 1'b0}, 10, 4, 1'b0);
    expect_frame({1'b1, 8'h0F, 1'b0}, 10, 4, 1'b1);
    expect_frame({1'b1, 8'hAA, 1'b0}, 10, 4, 1'b1);
    expect_frame({1'b1, 8'h55, 1'b0}, 10, 4, 1'b1);
    push(8'hF0);
    push(8'h0F);
    push(8'hAA);
    push(8'h55);
    tx_valid = 1'b0;
    step(6);
    check("t6_level_before", 32'(fifo_level), 32'd3);
    rst_n = 1'b0;
    step(1);
    check("t6_rst_uart_tx", 32'(uart_tx), 32'd1);
    check("t6_rst_busy", 32'(tx_busy), 32'd0);
    check("t6_rst_level", 32'(fifo_level), 32'd0);
    check("t6_rst_ready", 32'(tx_ready), 32'd1);
    rst_n = 1'b1;
    exp_q.delete();
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0) bad++;
      step(1);
    end
    check("t6_no_resume", 32'(bad), 32'd0);
    cfg_baud_div = '0;
    expect_frame({1'b1, 8'h5A, 1'b0}, 10, 2, 1'b0);
    push(8'h5A);
    tx_valid = 1'b0;
    measure_busy(n);
    check("t6_div0_busy_cycles", 32'(n), 32'd20);
    wait_idle();
    step(5);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
